// File: rtl/master_control_pkg.sv
// Shared definitions for the master tile scheduler: default geometry and FSM state encoding.
package master_control_pkg;

    localparam int unsigned SysArrRowsDefault = 16;
    localparam int unsigned SysArrColsDefault = 16;
    localparam int unsigned AddrWidthDefault  = 8;
    localparam int unsigned TileWDefault      = 4;

    typedef enum logic [2:0] {
        StIdle,
        StFillIssue,
        StFillWait,
        StCompIssue,
        StCompWait,
        StNext
    } sched_state_e;

endpackage

// File: rtl/master_tile_scheduler_if.sv
// Job request, fill-controller and compute-engine handshake bundle for the tile scheduler.
interface master_tile_scheduler_if #(
    parameter int unsigned SYS_ARR_ROWS = master_control_pkg::SysArrRowsDefault,
    parameter int unsigned SYS_ARR_COLS = master_control_pkg::SysArrColsDefault,
    parameter int unsigned ADDR_WIDTH   = master_control_pkg::AddrWidthDefault,
    parameter int unsigned TILE_W       = master_control_pkg::TileWDefault
) ();
    localparam int unsigned RowW = $clog2(SYS_ARR_ROWS);
    localparam int unsigned ColW = $clog2(SYS_ARR_COLS);

    logic                  start;
    logic                  done;
    logic                  abort;
    logic [TILE_W-1:0]     num_tiles;
    logic [RowW-1:0]       num_row;
    logic [ColW-1:0]       num_col;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] stride;
    logic                  fill_start;
    logic                  fill_done;
    logic [RowW-1:0]       fill_num_row;
    logic [ColW-1:0]       fill_num_col;
    logic [ADDR_WIDTH-1:0] fill_base_addr;
    logic                  comp_start;
    logic                  comp_done;
    logic [TILE_W-1:0]     tile_idx;
    logic                  aborted;

    modport master (
        input  start, abort, num_tiles, num_row, num_col, base_addr, stride, fill_done, comp_done,
        output done, fill_start, fill_num_row, fill_num_col, fill_base_addr, comp_start, tile_idx,
               aborted
    );

    modport slave (
        output start, abort, num_tiles, num_row, num_col, base_addr, stride, fill_done, comp_done,
        input  done, fill_start, fill_num_row, fill_num_col, fill_base_addr, comp_start, tile_idx,
               aborted
    );

endinterface

// File: rtl/master_busy_wait.sv
// Issue pulse plus seen-busy completion detect for a downstream block whose idle level
// only drops one cycle after it is started.
module master_busy_wait (
    input  logic clk,
    input  logic reset,
    input  logic i_issue,
    input  logic i_wait,
    input  logic i_done,
    output logic o_start,
    output logic o_finished
);
    logic r_seen_busy;

    // Cleared whenever the scheduler is outside the wait state, so each tile re-arms.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seen_busy <= 1'b0;
        end else begin
            r_seen_busy <= i_wait & (r_seen_busy | ~i_done);
        end
    end

    assign o_start    = i_issue;
    assign o_finished = i_wait & r_seen_busy & i_done;

endmodule

// File: rtl/master_tile_scheduler.sv
// Walks a job of num_tiles+1 tiles, sequencing a FIFO fill then a compute pass per tile.
module master_tile_scheduler
    import master_control_pkg::*;
#(
    parameter int unsigned SYS_ARR_ROWS = SysArrRowsDefault,
    parameter int unsigned SYS_ARR_COLS = SysArrColsDefault,
    parameter int unsigned ADDR_WIDTH   = AddrWidthDefault,
    parameter int unsigned TILE_W       = TileWDefault
) (
    input logic                    clk,
    input logic                    reset,
    master_tile_scheduler_if.master bus
);
    localparam int unsigned RowW = $clog2(SYS_ARR_ROWS);
    localparam int unsigned ColW = $clog2(SYS_ARR_COLS);

    sched_state_e          r_state;
    logic [TILE_W-1:0]     r_num_tiles;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [RowW-1:0]       r_fill_num_row;
    logic [ColW-1:0]       r_fill_num_col;
    logic [ADDR_WIDTH-1:0] r_fill_base_addr;
    logic [TILE_W-1:0]     r_tile_idx;
    logic                  r_aborted;

    logic w_fill_finished;
    logic w_comp_finished;

    master_busy_wait u_fill_wait (
        .clk        (clk),
        .reset      (reset),
        .i_issue    (r_state == StFillIssue),
        .i_wait     (r_state == StFillWait),
        .i_done     (bus.fill_done),
        .o_start    (bus.fill_start),
        .o_finished (w_fill_finished)
    );

    master_busy_wait u_comp_wait (
        .clk        (clk),
        .reset      (reset),
        .i_issue    (r_state == StCompIssue),
        .i_wait     (r_state == StCompWait),
        .i_done     (bus.comp_done),
        .o_start    (bus.comp_start),
        .o_finished (w_comp_finished)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= StIdle;
            r_num_tiles      <= '0;
            r_stride         <= '0;
            r_fill_num_row   <= '0;
            r_fill_num_col   <= '0;
            r_fill_base_addr <= '0;
            r_tile_idx       <= '0;
            r_aborted        <= 1'b0;
        end else begin
            r_aborted <= 1'b0;
            if (r_state != StIdle && bus.abort) begin
                r_state   <= StIdle;
                r_aborted <= 1'b1;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        // Abort arriving with start cancels the request outright.
                        if (bus.start && !bus.abort) begin
                            r_num_tiles      <= bus.num_tiles;
                            r_stride         <= bus.stride;
                            r_fill_num_row   <= bus.num_row;
                            r_fill_num_col   <= bus.num_col;
                            r_fill_base_addr <= bus.base_addr;
                            r_tile_idx       <= '0;
                            r_state          <= StFillIssue;
                        end
                    end
                    StFillIssue: r_state <= StFillWait;
                    StFillWait:  if (w_fill_finished) r_state <= StCompIssue;
                    StCompIssue: r_state <= StCompWait;
                    StCompWait:  if (w_comp_finished) r_state <= StNext;
                    StNext: begin
                        if (r_tile_idx == r_num_tiles) begin
                            r_state <= StIdle;
                        end else begin
                            r_tile_idx       <= r_tile_idx + 1'b1;
                            r_fill_base_addr <= r_fill_base_addr + r_stride;
                            r_state          <= StFillIssue;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign bus.done           = (r_state == StIdle);
    assign bus.fill_num_row   = r_fill_num_row;
    assign bus.fill_num_col   = r_fill_num_col;
    assign bus.fill_base_addr = r_fill_base_addr;
    assign bus.tile_idx       = r_tile_idx;
    assign bus.aborted        = r_aborted;

endmodule

// File: tb/tb_master_tile_scheduler.sv
// Self-checking bench: job-level reference model plus behavioural fill/compute responders.
module tb_master_tile_scheduler;

    localparam int PhFillIssue = 1;
    localparam int PhFillWait  = 2;
    localparam int PhCompIssue = 3;
    localparam int PhCompWait  = 4;
    localparam int PhNext      = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    master_tile_scheduler_if bus ();

    master_tile_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: job progress expressed as tile number plus phase.
    bit m_active, m_seen, m_aborted;
    int m_phase, m_tile, m_nt, m_row, m_col, m_base, m_stride;

    // Downstream responders: cycles idle-high after start, then cycles busy-low.
    int f_hi, f_lo, c_hi, c_lo;
    bit ds_rand = 1'b0;
    int f_hold = 0, f_busy = 3, c_hold = 0, c_busy = 3;

    bit         s_start, s_abort;
    logic [3:0] s_nt, s_row, s_col;
    logic [7:0] s_base, s_stride;

    int obs_fill, obs_comp, obs_abort, obs_done_low, cyc, last_fill_cyc, last_comp_cyc;
    logic [7:0] q_addr[$];
    int q_tile[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_seen = 0; m_aborted = 0; m_phase = 0; m_tile = 0;
        m_nt = 0; m_row = 0; m_col = 0; m_base = 0; m_stride = 0;
        f_hi = 0; f_lo = 0; c_hi = 0; c_lo = 0;
    endtask

    task automatic clear_obs();
        obs_fill = 0; obs_comp = 0; obs_abort = 0; obs_done_low = 0;
        last_fill_cyc = 0; last_comp_cyc = 0;
        q_addr.delete(); q_tile.delete();
    endtask

    task automatic compare_all();
        check("done", bus.done, !m_active);
        check("fill_start", bus.fill_start, m_active && m_phase == PhFillIssue);
        check("comp_start", bus.comp_start, m_active && m_phase == PhCompIssue);
        check("aborted", bus.aborted, m_aborted);
        check("tile_idx", bus.tile_idx, m_tile);
        check("fill_base_addr", bus.fill_base_addr, (m_base + m_tile * m_stride) % 256);
        check("fill_num_row", bus.fill_num_row, m_row);
        check("fill_num_col", bus.fill_num_col, m_col);
        cyc++;
        if (bus.fill_start) begin
            obs_fill++; last_fill_cyc = cyc;
            q_addr.push_back(bus.fill_base_addr); q_tile.push_back(int'(bus.tile_idx));
        end
        if (bus.comp_start) begin obs_comp++; last_comp_cyc = cyc; end
        if (bus.aborted) obs_abort++;
        if (!bus.done) obs_done_low++;
    endtask

    task automatic step();
        bit fd, cd, exp_fs, exp_cs;
        fd = (f_hi > 0) || (f_lo == 0);
        cd = (c_hi > 0) || (c_lo == 0);
        bus.start = s_start; bus.abort = s_abort; bus.num_tiles = s_nt;
        bus.num_row = s_row; bus.num_col = s_col; bus.base_addr = s_base; bus.stride = s_stride;
        bus.fill_done = fd; bus.comp_done = cd;
        if (f_hi > 0) f_hi--; else if (f_lo > 0) f_lo--;
        if (c_hi > 0) c_hi--; else if (c_lo > 0) c_lo--;
        exp_fs = m_active && m_phase == PhFillIssue;
        exp_cs = m_active && m_phase == PhCompIssue;
        if (exp_fs) begin
            f_hi = ds_rand ? int'($urandom_range(0, 2)) : f_hold;
            f_lo = ds_rand ? int'($urandom_range(1, 4)) : f_busy;
        end
        if (exp_cs) begin
            c_hi = ds_rand ? int'($urandom_range(0, 2)) : c_hold;
            c_lo = ds_rand ? int'($urandom_range(1, 4)) : c_busy;
        end
        m_aborted = 0;
        if (!m_active) begin
            if (s_start && !s_abort) begin
                m_active = 1; m_phase = PhFillIssue; m_tile = 0; m_nt = s_nt;
                m_row = s_row; m_col = s_col; m_base = s_base; m_stride = s_stride;
            end
        end else if (s_abort) begin
            m_active = 0; m_aborted = 1;
        end else begin
            case (m_phase)
                PhFillIssue: begin m_phase = PhFillWait; m_seen = 0; end
                PhFillWait:  if (fd && m_seen) m_phase = PhCompIssue; else if (!fd) m_seen = 1;
                PhCompIssue: begin m_phase = PhCompWait; m_seen = 0; end
                PhCompWait:  if (cd && m_seen) m_phase = PhNext; else if (!cd) m_seen = 1;
                default: begin
                    if (m_tile == m_nt) m_active = 0;
                    else begin m_tile++; m_phase = PhFillIssue; end
                end
            endcase
        end
        @(posedge clk);
        #1;
        compare_all();
        s_start = 0; s_abort = 0;
    endtask

    task automatic start_job(input int nt, input int row, input int col, input int base,
                             input int stride);
        s_nt = 4'(nt); s_row = 4'(row); s_col = 4'(col);
        s_base = 8'(base); s_stride = 8'(stride); s_start = 1;
        step();
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (m_active && k < budget) begin step(); k++; end
        if (m_active) begin
            n_checks++; n_fail++;
            $display("FAIL job_timeout: still busy after %0d cycles, expected idle", budget);
        end
    endtask

    task automatic wait_phase(input int tile, input int phase, input int budget);
        int k = 0;
        while (!(m_active && m_tile == tile && m_phase == phase) && k < budget) begin
            step(); k++;
        end
        n_checks++;
        if (!(m_active && m_tile == tile && m_phase == phase)) begin
            n_fail++;
            $display("FAIL phase_timeout: tile %0d phase %0d not reached, expected reached", tile,
                     phase);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_fill_start"}, bus.fill_start, 0);
        check({tag, "_comp_start"}, bus.comp_start, 0);
        check({tag, "_aborted"}, bus.aborted, 0);
        check({tag, "_tile_idx"}, bus.tile_idx, 0);
        check({tag, "_addr"}, bus.fill_base_addr, 0);
        check({tag, "_row"}, bus.fill_num_row, 0);
        check({tag, "_col"}, bus.fill_num_col, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_a [4];
        exp_a[0] = 8'hF0; exp_a[1] = 8'hF8; exp_a[2] = 8'h00; exp_a[3] = 8'h08;
        s_start = 0; s_abort = 0; s_nt = 0; s_row = 0; s_col = 0; s_base = 0; s_stride = 0;
        bus.start = 0; bus.abort = 0; bus.num_tiles = 0; bus.num_row = 0; bus.num_col = 0;
        bus.base_addr = 0; bus.stride = 0; bus.fill_done = 1; bus.comp_done = 1;
        model_reset();
        clear_obs();
        cyc = 0;

        #2;
        check_reset_values("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        compare_all();

        // Single tile, 3-cycle busy responders.
        clear_obs();
        start_job(0, 3, 5, 'h10, 'h20);
        wait_idle(100);
        step();
        check("t1_fill_starts", obs_fill, 1);
        check("t1_comp_starts", obs_comp, 1);
        check("t1_addr", q_addr.size() > 0 ? q_addr[0] : 8'hxx, 8'h10);
        check("t1_fill_to_comp", last_comp_cyc - last_fill_cyc, 5);
        check("t1_busy_cycles", obs_done_low, 11);
        check("t1_done", bus.done, 1);

        // Four tiles with address wrap.
        f_busy = 1; c_busy = 1;
        clear_obs();
        start_job(3, 1, 2, 'hF0, 'h08);
        wait_idle(200);
        check("t2_fill_starts", q_addr.size(), 4);
        for (int i = 0; i < q_addr.size() && i < 4; i++) begin
            check("t2_addr", q_addr[i], exp_a[i]);
            check("t2_tile", q_tile[i], i);
        end

        // Fill controller stays idle-high for 2 cycles after its start.
        f_hold = 2; f_busy = 3; c_busy = 2;
        clear_obs();
        start_job(0, 4, 4, 'h22, 'h01);
        wait_idle(100);
        check("t3_fill_to_comp", last_comp_cyc - last_fill_cyc, 7);

        // Abort in compute wait of tile 1.
        f_hold = 0; f_busy = 3; c_busy = 3;
        start_job(2, 6, 6, 'h80, 'h10);
        wait_phase(1, PhCompWait, 200);
        clear_obs();
        s_abort = 1;
        step();
        check("t4_aborted_now", bus.aborted, 1);
        check("t4_done_now", bus.done, 1);
        repeat (10) step();
        check("t4_abort_pulses", obs_abort, 1);
        check("t4_no_fill", obs_fill, 0);
        check("t4_no_comp", obs_comp, 0);

        // Start during a job is ignored.
        clear_obs();
        start_job(1, 2, 7, 'h40, 'h04);
        repeat (3) step();
        s_nt = 4'd9; s_row = 4'hF; s_col = 4'hF; s_base = 8'h00; s_stride = 8'hFF; s_start = 1;
        step();
        wait_idle(200);
        check("t5_row", bus.fill_num_row, 2);
        check("t5_col", bus.fill_num_col, 7);
        check("t5_tile", bus.tile_idx, 1);
        check("t5_addr", bus.fill_base_addr, 8'h44);
        check("t5_fill_starts", obs_fill, 2);

        // Asynchronous reset between edges while waiting on the fill controller.
        start_job(2, 9, 3, 'h33, 'h05);
        wait_phase(0, PhFillWait, 50);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("mid");
        @(negedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        clear_obs();
        start_job(2, 9, 3, 'h33, 'h05);
        wait_idle(200);
        check("t6_fill_starts", obs_fill, 3);
        check("t6_comp_starts", obs_comp, 3);

        // Randomised traffic including maximum tile count and stray start/abort.
        ds_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            if (!m_active) begin
                s_start = ($urandom_range(0, 3) == 0);
                s_abort = ($urandom_range(0, 29) == 0);
            end else begin
                s_start = ($urandom_range(0, 24) == 0);
                s_abort = ($urandom_range(0, 59) == 0);
            end
            s_nt = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            s_row = 4'($urandom); s_col = 4'($urandom);
            s_base = 8'($urandom); s_stride = 8'($urandom);
            step();
        end
        wait_idle(1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/master_tile_scheduler.md
MASTER_TILE_SCHEDULER -- requirements
Module: master_tile_scheduler

Interface
REQ-001 SHALL have parameter SYS_ARR_ROWS, default 16, systolic array rows.
REQ-002 SHALL have parameter SYS_ARR_COLS, default 16, systolic array columns.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, weight memory address width.
REQ-004 SHALL have parameter TILE_W, default 4, tile count width (code n means n+1 tiles).
REQ-005 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, single-cycle job request.
REQ-008 SHALL have port done, output, 1, high while idle.
REQ-009 SHALL have port abort, input, 1, synchronous job cancel.
REQ-010 SHALL have port num_tiles, input, TILE_W, tiles minus one.
REQ-011 SHALL have port num_row, input, $clog2(SYS_ARR_ROWS), rows per tile minus one.
REQ-012 SHALL have port num_col, input, $clog2(SYS_ARR_COLS), columns per tile minus one.
REQ-013 SHALL have port base_addr, input, ADDR_WIDTH, first tile weight address.
REQ-014 SHALL have port stride, input, ADDR_WIDTH, address step between tiles.
REQ-015 SHALL have port fill_start, output, 1, one-cycle start pulse to the FIFO fill controller.
REQ-016 SHALL have port fill_done, input, 1, fill controller idle level (high = idle).
REQ-017 SHALL have port fill_num_row, output, $clog2(SYS_ARR_ROWS), held tile row code.
REQ-018 SHALL have port fill_num_col, output, $clog2(SYS_ARR_COLS), held tile column code.
REQ-019 SHALL have port fill_base_addr, output, ADDR_WIDTH, current tile weight address.
REQ-020 SHALL have port comp_start, output, 1, one-cycle start pulse to the compute engine.
REQ-021 SHALL have port comp_done, input, 1, compute engine idle level (high = idle).
REQ-022 SHALL have port tile_idx, output, TILE_W, index of tile in progress.
REQ-023 SHALL have port aborted, output, 1, one-cycle pulse when a job is cancelled.

Function
REQ-024 SHALL implement states IDLE, FILL_ISSUE, FILL_WAIT, COMP_ISSUE, COMP_WAIT, NEXT.
REQ-025 SHALL latch num_tiles, num_row, num_col, base_addr, stride on start in IDLE and move to FILL_ISSUE; start outside IDLE is ignored.
REQ-026 SHALL assert fill_start exactly in FILL_ISSUE (one cycle), then enter FILL_WAIT.
REQ-027 SHALL leave FILL_WAIT only when fill_done is high after having been sampled low at least once in that state (seen-busy flag), since the fill controller's done falls one cycle after start.
REQ-028 SHALL apply the same issue/seen-busy rule to comp_start/comp_done via COMP_ISSUE and COMP_WAIT.
REQ-029 SHALL, in NEXT, go to IDLE if tile_idx == latched num_tiles, else increment tile_idx, add stride to fill_base_addr (mod 2^ADDR_WIDTH wrap), and go to FILL_ISSUE.
REQ-030 SHALL hold fill_num_row, fill_num_col, fill_base_addr stable from FILL_ISSUE through COMP_WAIT of each tile.
REQ-031 SHALL give minimum latency start -> first fill_start of 1 cycle, and NEXT -> next fill_start of 1 cycle.
REQ-032 SHALL assert done combinationally as (state == IDLE).
REQ-033 SHALL, on abort in any non-IDLE state, go to IDLE next cycle, suppress any pending start pulse, and pulse aborted; abort in IDLE has no effect; abort wins over simultaneous start.
REQ-034 SHALL handle num_tiles = 0 as exactly one tile and num_tiles = 2^TILE_W-1 without tile_idx overflow.

Reset
REQ-035 SHALL, while reset is low, force state IDLE, done=1, fill_start=0, comp_start=0, aborted=0, tile_idx=0, fill_base_addr=0, fill_num_row=0, fill_num_col=0, seen-busy flags=0, regardless of clk.
REQ-036 SHALL not signal downstream blocks on reset mid-job; those blocks share the same reset.

Structure
REQ-037 SHALL place the state encoding and default parameter values in the shared master_control package.
REQ-038 SHALL use one sub-module, master_busy_wait, implementing the issue-pulse plus seen-busy done detection, instantiated twice (fill, compute).

Verification
REQ-039 SHALL cover: num_tiles=0, base_addr=0x10, stride=0x20, fill/comp models busy 3 cycles -> one fill_start, one comp_start, fill_base_addr=0x10, done back high.
REQ-040 SHALL cover: num_tiles=3, base_addr=0xF0, stride=0x08 -> fill_base_addr sequence 0xF0, 0xF8, 0x00, 0x08, tile_idx 0..3.
REQ-041 SHALL cover: fill_done held high for 2 cycles after fill_start before falling -> no premature COMP_ISSUE; comp_start only after fill_done low-then-high.
REQ-042 SHALL cover: abort during COMP_WAIT of tile 1 -> aborted pulse 1 cycle, done high next cycle, no further start pulses.
REQ-043 SHALL cover: reset asserted low mid FILL_WAIT between clock edges -> all outputs at reset values immediately; start after release runs a full job.
REQ-044 SHALL cover: start asserted during a job -> ignored, latched configuration unchanged.
